rst_set_release_seq: RTL and testbench



---
 rtl/rst_set_release_seq_pkg.sv | 30 +++
 rtl/rst_set_release_seq_sync_chain.sv | 27 ++
 rtl/rst_set_release_seq.sv | 163 ++++++++++++++++
 tb/tb_rst_set_release_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_set_release_seq_pkg.sv
// rtl/rst_set_release_seq_pkg.sv - shared types and helpers for the reset/set release sequencer
package rst_set_release_seq_pkg;

  typedef enum logic [2:0] {
    SYNC,
    HOLD,
    RELEASE,
    RUN,
    PULSE
  } state_e;

  // Counters only ever reach max_count, so they need room for 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic bit params_ok(input int n_ch, input int sync_stages,
                                   input int hold_cycles, input int pulse_cycles,
                                   input int stagger);
    return (n_ch >= 1) && (sync_stages >= 2) && (hold_cycles >= 1) &&
           (pulse_cycles >= 1) && (stagger >= 0);
  endfunction

endpackage

// File: rtl/rst_set_release_seq_sync_chain.sv
// rtl/rst_set_release_seq_sync_chain.sv - async-assert / sync-deassert reset synchroniser
module rst_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_o
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/rst_set_release_seq.sv
// rtl/rst_set_release_seq.sv - staggered synchronous release of RN/SETN pins with software re-init
module rst_set_release_seq
  import rst_set_release_seq_pkg::*;
#(
  parameter int              N_CH         = 4,
  parameter int              SYNC_STAGES  = 2,
  parameter int              HOLD_CYCLES  = 8,
  parameter int              STAGGER      = 1,
  parameter int              PULSE_CYCLES = 4,
  parameter logic [N_CH-1:0] INIT_SET     = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            SW_REQ,
  output logic            SW_ACK,
  output logic            READY,
  output logic [N_CH-1:0] RN_O,
  output logic [N_CH-1:0] SETN_O
);

  localparam int CNT_W = cnt_width(max3(HOLD_CYCLES, PULSE_CYCLES, STAGGER));
  localparam int IDX_W = cnt_width(N_CH);

  generate
    if (!params_ok(N_CH, SYNC_STAGES, HOLD_CYCLES, PULSE_CYCLES, STAGGER)) begin : g_bad_params
      $error("rst_set_release_seq: illegal parameter combination");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_CH-1:0]   rn_q, rn_d;
  logic [N_CH-1:0]   setn_q, setn_d;
  logic              ready_q, ready_d;
  logic              ack_q, ack_d;
  logic              swp_q, swp_d;
  logic              sync_done;
  logic              rel_now;

  rst_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (CLK),
    .rst    (RST),
    .sync_o (sync_done)
  );

  // The edge that leaves SYNC already counts as the first hold edge, so the
  // first release lands exactly SYNC_STAGES + HOLD_CYCLES edges after reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rn_d    = rn_q;
    setn_d  = setn_q;
    ready_d = ready_q;
    ack_d   = 1'b0;
    swp_d   = swp_q;
    rel_now = 1'b0;

    case (state_q)
      SYNC: begin
        if (sync_done) begin
          if (HOLD_CYCLES <= 1) begin
            rel_now = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (int'(cnt_q) + 1 >= HOLD_CYCLES) begin
          rel_now = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (idx_q == IDX_W'(N_CH)) begin
          state_d = RUN;
          ready_d = 1'b1;
          ack_d   = swp_q;
          swp_d   = 1'b0;
        end else if (int'(cnt_q) + 1 >= STAGGER) begin
          rel_now = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (SW_REQ) begin
          state_d = PULSE;
          cnt_d   = '0;
          idx_d   = '0;
          rn_d    = INIT_SET;
          setn_d  = ~INIT_SET;
          ready_d = 1'b0;
          swp_d   = 1'b1;
        end
      end
      PULSE: begin
        if (int'(cnt_q) + 1 >= PULSE_CYCLES) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = '0;
        idx_d   = '0;
        rn_d    = INIT_SET;
        setn_d  = ~INIT_SET;
        ready_d = 1'b0;
        swp_d   = 1'b0;
      end
    endcase

    // With STAGGER == 0 every channel goes at once and the index jumps to the end.
    if (rel_now) begin
      state_d = RELEASE;
      cnt_d   = '0;
      for (int i = 0; i < N_CH; i++) begin
        if ((STAGGER == 0) || (IDX_W'(i) == idx_q)) begin
          rn_d[i]   = 1'b1;
          setn_d[i] = 1'b1;
        end
      end
      idx_d = (STAGGER == 0) ? IDX_W'(N_CH) : idx_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      rn_q    <= INIT_SET;
      setn_q  <= ~INIT_SET;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      swp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rn_q    <= rn_d;
      setn_q  <= setn_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      swp_q   <= swp_d;
    end
  end

  assign RN_O   = rn_q;
  assign SETN_O = setn_q;
  assign READY  = ready_q;
  assign SW_ACK = ack_q;

endmodule

// File: tb/tb_rst_set_release_seq.sv
// tb/tb_rst_set_release_seq.sv - self-checking bench for rst_set_release_seq
module tb_rst_set_release_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks   = 0;
  int failures = 0;

  logic       rst0 = 1'b1, req0 = 1'b0, ack0, rdy0;
  logic       rst1 = 1'b1, req1 = 1'b0, ack1, rdy1;
  logic       rst2 = 1'b1, req2 = 1'b0, ack2, rdy2;
  logic [3:0] rn0, setn0, rn1, setn1, rn2, setn2;

  rst_set_release_seq u_def (
    .CLK(clk), .RST(rst0), .SW_REQ(req0), .SW_ACK(ack0), .READY(rdy0),
    .RN_O(rn0), .SETN_O(setn0)
  );

  rst_set_release_seq #(.INIT_SET(4'b1010)) u_mix (
    .CLK(clk), .RST(rst1), .SW_REQ(req1), .SW_ACK(ack1), .READY(rdy1),
    .RN_O(rn1), .SETN_O(setn1)
  );

  rst_set_release_seq #(.STAGGER(0), .HOLD_CYCLES(1)) u_fast (
    .CLK(clk), .RST(rst2), .SW_REQ(req2), .SW_ACK(ack2), .READY(rdy2),
    .RN_O(rn2), .SETN_O(setn2)
  );

  // Expected {RN, SETN, READY, SW_ACK} k edges after the sequence start,
  // where channel i is due at edge first + i*stg.
  function automatic logic [9:0] exp_out(input int k, input int first, input int stg,
                                         input logic [3:0] init, input bit sw);
    logic [3:0] rel;
    int last;
    last = first + 3 * stg;
    for (int i = 0; i < 4; i++) rel[i] = (k >= first + i * stg);
    return {rel | init, rel | ~init, (k >= last + 1), (sw && (k == last + 1))};
  endfunction

  task automatic test_reset();
    int start;
    logic [9:0] want;
    @(negedge clk);
    rst0 = 1'b1;
    #1;
    want = exp_out(0, 10, 1, 4'b0000, 0);
    checks++;
    if ({rn0, setn0, rdy0, ack0} !== want) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", {rn0, setn0, rdy0, ack0}, want);
    end
    @(negedge clk);
    rst0 = 1'b0;
    start = edge_n;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      want = exp_out(edge_n - start, 10, 1, 4'b0000, 0);
      checks++;
      if ({rn0, setn0, rdy0, ack0} !== want) begin
        failures++;
        $display("FAIL reset_seq edge=%0d got=%b want=%b", edge_n - start, {rn0, setn0, rdy0, ack0}, want);
      end
    end
  endtask

  task automatic test_sw_reinit();
    int e0, w, gap;
    logic [9:0] want;
    for (int r = 0; r < 3; r++) begin
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1 || ack0 !== 1'b0) begin
          failures++;
          $display("FAIL run_idle ready=%b ack=%b want ready=1 ack=0", rdy0, ack0);
        end
      end
      w = $urandom_range(1, 3);
      req0 = 1'b1;
      e0 = edge_n + 1;
      for (int k = 0; k <= 17; k++) begin
        @(negedge clk);
        if (edge_n - e0 >= w - 1) req0 = 1'b0;
        want = exp_out(edge_n - e0, 12, 1, 4'b0000, 1);
        checks++;
        if ({rn0, setn0, rdy0, ack0} !== want) begin
          failures++;
          $display("FAIL sw_reinit e0+%0d got=%b want=%b", edge_n - e0, {rn0, setn0, rdy0, ack0}, want);
        end
      end
    end
  endtask

  task automatic test_rst_mid_release();
    int start, stop;
    logic [9:0] want;
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    start = edge_n;
    stop = $urandom_range(11, 12);
    for (int k = 1; k <= stop; k++) begin
      @(negedge clk);
      want = exp_out(edge_n - start, 10, 1, 4'b0000, 0);
      checks++;
      if ({rn0, setn0, rdy0, ack0} !== want) begin
        failures++;
        $display("FAIL pre_abort edge=%0d got=%b want=%b", edge_n - start, {rn0, setn0, rdy0, ack0}, want);
      end
    end
    #2;
    rst0 = 1'b1;
    #1;
    want = exp_out(0, 10, 1, 4'b0000, 0);
    checks++;
    if ({rn0, setn0, rdy0, ack0} !== want) begin
      failures++;
      $display("FAIL async_assert got=%b want=%b", {rn0, setn0, rdy0, ack0}, want);
    end
    @(negedge clk);
    checks++;
    if ({rn0, setn0, rdy0, ack0} !== want) begin
      failures++;
      $display("FAIL held_in_reset got=%b want=%b", {rn0, setn0, rdy0, ack0}, want);
    end
    rst0 = 1'b0;
    start = edge_n;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      want = exp_out(edge_n - start, 10, 1, 4'b0000, 0);
      checks++;
      if ({rn0, setn0, rdy0, ack0} !== want) begin
        failures++;
        $display("FAIL restart_seq edge=%0d got=%b want=%b", edge_n - start, {rn0, setn0, rdy0, ack0}, want);
      end
    end
  endtask

  task automatic run_mix_sequence(input int req_at, input string name);
    int start;
    logic [9:0] want;
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    want = exp_out(0, 10, 1, 4'b1010, 0);
    checks++;
    if ({rn1, setn1, rdy1, ack1} !== want) begin
      failures++;
      $display("FAIL %s_reset got=%b want=%b", name, {rn1, setn1, rdy1, ack1}, want);
    end
    @(negedge clk);
    rst1 = 1'b0;
    start = edge_n;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (edge_n - start == req_at) req1 = 1'b1;
      if (edge_n - start == req_at + 1) req1 = 1'b0;
      want = exp_out(edge_n - start, 10, 1, 4'b1010, 0);
      checks++;
      if ({rn1, setn1, rdy1, ack1} !== want) begin
        failures++;
        $display("FAIL %s edge=%0d got=%b want=%b", name, edge_n - start, {rn1, setn1, rdy1, ack1}, want);
      end
      checks++;
      if ((~rn1 & ~setn1) !== 4'b0000) begin
        failures++;
        $display("FAIL %s_invariant edge=%0d rn=%b setn=%b", name, edge_n - start, rn1, setn1);
      end
    end
  endtask

  task automatic test_init_set();
    run_mix_sequence(-5, "init_set");
  endtask

  task automatic test_sw_in_hold();
    run_mix_sequence($urandom_range(1, 8), "sw_in_hold");
  endtask

  task automatic test_stagger0();
    int start, e0, gap;
    logic [9:0] want;
    @(negedge clk);
    rst2 = 1'b0;
    start = edge_n;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      want = exp_out(edge_n - start, 3, 0, 4'b0000, 0);
      checks++;
      if ({rn2, setn2, rdy2, ack2} !== want) begin
        failures++;
        $display("FAIL stagger0_seq edge=%0d got=%b want=%b", edge_n - start, {rn2, setn2, rdy2, ack2}, want);
      end
    end
    gap = $urandom_range(0, 3);
    for (int g = 0; g < gap; g++) @(negedge clk);
    req2 = 1'b1;
    e0 = edge_n + 1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      want = exp_out((edge_n - e0) % 7, 5, 0, 4'b0000, 1);
      checks++;
      if ({rn2, setn2, rdy2, ack2} !== want) begin
        failures++;
        $display("FAIL sw_held e0+%0d got=%b want=%b", edge_n - e0, {rn2, setn2, rdy2, ack2}, want);
      end
    end
    req2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sw_reinit();
    test_rst_mid_release();
    test_init_set();
    test_sw_in_hold();
    test_stagger0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
